mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, the maximum cycles spent in WAIT_HI plus WAIT_LO before abort.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Ports r0_req / r1_req, input, 1 bit each: requester 0 (CPU) / requester 1 (loader) transaction request.
REQ-005 Ports r0_we / r1_we, input, 1 bit each: 1 = write, 0 = read.
REQ-006 Ports r0_addr / r1_addr, input, 32 bits each: byte address.
REQ-007 Ports r0_wdata / r1_wdata, input, 32 bits each: write data.
REQ-008 Ports r0_mask / r1_mask, input, 4 bits each: sign_mask encoding; bit3 = sign-extend, [2:0] in {001 byte, 011 half, 111 word}.
REQ-009 Ports r0_ack / r1_ack, output, 1 bit each: one-cycle completion pulse.
REQ-010 Ports r0_err / r1_err, output, 1 bit each: valid with ack; 1 = aborted or rejected.
REQ-011 Ports r0_rdata / r1_rdata, output, 32 bits each: registered read result.
REQ-012 Ports m_addr, m_wdata (32 bits), m_sign_mask (4 bits), m_memread, m_memwrite (1 bit each), output: drive the data-memory port.
REQ-013 Port m_rdata, input, 32 bits: memory read data.
REQ-014 Port m_stall, input, 1 bit: memory busy flag (clk_stall).
REQ-015 Port busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-016 The block SHALL implement the states IDLE, ISSUE, WAIT_HI, WAIT_LO and DONE.
REQ-017 IDLE: when any req is high, the block SHALL grant one requester, latch its we/addr/wdata/mask into internal registers and go to ISSUE.
REQ-018 Arbitration SHALL be round-robin: with a single request, grant it; with both requests, grant the requester not equal to last_gnt; last_gnt updates on grant.
REQ-019 In IDLE, a request whose mask[2:0] is not 001, 011 or 111 SHALL NOT be issued; the block SHALL go to DONE with err=1 and rdata unchanged.
REQ-020 ISSUE SHALL last exactly one cycle, driving m_memread=~we and m_memwrite=we with the latched fields; next state is WAIT_HI.
REQ-021 m_memread and m_memwrite SHALL be 0 in every state except ISSUE.
REQ-022 m_addr, m_wdata and m_sign_mask SHALL hold the latched values from ISSUE until IDLE.
REQ-023 WAIT_HI: on m_stall=1, go to WAIT_LO.
REQ-024 WAIT_LO: on m_stall=0, go to DONE; for a read, capture m_rdata into the granted rN_rdata on the same edge.
REQ-025 A wait counter SHALL clear on entry to ISSUE and increment each cycle in WAIT_HI or WAIT_LO; at TIMEOUT it SHALL force DONE with err=1, leaving rdata unchanged.
REQ-026 DONE SHALL last one cycle, assert ack (and err, when applicable) for the granted requester only, then return to IDLE.
REQ-027 Writes SHALL leave rN_rdata unchanged.
REQ-028 Nominal latency: with IDLE sampling req at edge E, ack SHALL be high in the cycle after edge E+4 (memory stall of 2 cycles).
REQ-029 A requester SHALL hold req and its fields stable until it samples ack; req still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-030 A req rising while the block is not in IDLE SHALL wait, with no loss, until the block returns to IDLE.

Reset
REQ-031 Asserting reset SHALL immediately force IDLE and last_gnt=1, and clear the wait counter, every ack, err, rdata, m_* output and busy to 0.
REQ-032 Reset during any state SHALL abort the transaction with no ack; after release, a held req is re-arbitrated, with r0 winning a tie.

Verification
REQ-033 r0 reads addr 0x10 (mask 0111), memory word 0xDEADBEEF -> m_memread high 1 cycle; r0_ack after edge E+4; r0_rdata=0xDEADBEEF; r0_err=0.
REQ-034 r0 and r1 request on the same cycle after reset -> r0 granted first; r1 issued in the ISSUE after r0's DONE; two back-to-back pairs alternate r0,r1,r0,r1.
REQ-035 r1 writes 0x000000AB, mask 0001, addr 0x5 -> m_memwrite=1, m_addr=0x5, m_wdata=0xAB for exactly 1 cycle; r1_ack with err=0; r1_rdata unchanged.
REQ-036 r0 request with mask 0010 -> no m_memread/m_memwrite pulse; r0_ack and r0_err high in the cycle after the grant edge.
REQ-037 m_stall held 0 after ISSUE -> ack with err=1 after TIMEOUT=16 wait cycles; rdata unchanged.
REQ-038 Reset asserted in WAIT_LO -> all outputs 0 asynchronously, no ack; after release, r0 is granted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-requester front end for a single data-memory port. Requester 0 (CPU)
//   and requester 1 (loader) are arbitrated round-robin. The granted request
//   is latched, issued for one cycle, and then the arbiter follows the memory
//   stall handshake (stall rises, then falls) to detect completion. A wait
//   counter aborts a transaction that never completes. Requests with an
//   illegal size encoding are rejected without touching memory.
//
// Ports
//   clk, reset                : clock, asynchronous active-high reset
//   rN_req/we/addr/wdata/mask : requester N transaction (held until ack)
//   rN_ack, rN_err            : one-cycle completion pulse, error qualifier
//   rN_rdata                  : registered read result for requester N
//   m_addr/wdata/sign_mask    : latched transaction fields to memory
//   m_memread, m_memwrite     : one-cycle command strobes (ISSUE only)
//   m_rdata, m_stall          : memory read data, memory busy flag
//   busy                      : arbiter is not idle
module mem_port_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        r0_req,
   input  logic        r0_we,
   input  logic [31:0] r0_addr,
   input  logic [31:0] r0_wdata,
   input  logic [3:0]  r0_mask,
   output logic        r0_ack,
   output logic        r0_err,
   output logic [31:0] r0_rdata,
   input  logic        r1_req,
   input  logic        r1_we,
   input  logic [31:0] r1_addr,
   input  logic [31:0] r1_wdata,
   input  logic [3:0]  r1_mask,
   output logic        r1_ack,
   output logic        r1_err,
   output logic [31:0] r1_rdata,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_sign_mask,
   output logic        m_memread,
   output logic        m_memwrite,
   input  logic [31:0] m_rdata,
   input  logic        m_stall,
   output logic        busy
);

   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE} state_t;

   state_t        state, state_nx;
   logic          last_gnt, gnt, lat_we, err_q;
   logic [31:0]   lat_addr, lat_wdata;
   logic [3:0]    lat_mask;
   logic [CW-1:0] wait_cnt;

   logic          any_req, pick, sel_we, mask_ok, timeout;
   logic [31:0]   sel_addr, sel_wdata;
   logic [3:0]    sel_mask;

   // Round-robin: on a tie the requester that did not win last time is taken.
   assign any_req   = r0_req | r1_req;
   assign pick      = (r0_req & r1_req) ? ~last_gnt : r1_req;
   assign sel_we    = pick ? r1_we    : r0_we;
   assign sel_addr  = pick ? r1_addr  : r0_addr;
   assign sel_wdata = pick ? r1_wdata : r0_wdata;
   assign sel_mask  = pick ? r1_mask  : r0_mask;
   assign mask_ok   = (sel_mask[2:0] == 3'b001) | (sel_mask[2:0] == 3'b011) |
                      (sel_mask[2:0] == 3'b111);
   // Last permitted wait cycle; reaching it without completion aborts.
   assign timeout   = (wait_cnt == CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (any_req) state_nx = mask_ok ? ISSUE : DONE;
         ISSUE:   state_nx = WAIT_HI;
         WAIT_HI: if (m_stall) state_nx = WAIT_LO;
                  else if (timeout) state_nx = DONE;
         WAIT_LO: if (!m_stall || timeout) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_gnt  <= 1'b1;
         gnt       <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_mask  <= '0;
         err_q     <= 1'b0;
         wait_cnt  <= '0;
         r0_rdata  <= '0;
         r1_rdata  <= '0;
      end else begin
         case (state)
            IDLE: if (any_req) begin
               gnt       <= pick;
               last_gnt  <= pick;
               lat_we    <= sel_we;
               lat_addr  <= sel_addr;
               lat_wdata <= sel_wdata;
               lat_mask  <= sel_mask;
               err_q     <= ~mask_ok;
               wait_cnt  <= '0;
            end
            WAIT_HI: begin
               wait_cnt <= wait_cnt + 1'b1;
               if (!m_stall && timeout) err_q <= 1'b1;
            end
            WAIT_LO: begin
               wait_cnt <= wait_cnt + 1'b1;
               // Completion wins over a timeout landing on the same cycle.
               if (!m_stall) begin
                  if (!lat_we) begin
                     if (gnt) r1_rdata <= m_rdata;
                     else     r0_rdata <= m_rdata;
                  end
               end else if (timeout) begin
                  err_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign r0_ack      = (state == DONE) & ~gnt;
   assign r1_ack      = (state == DONE) &  gnt;
   assign r0_err      = r0_ack & err_q;
   assign r1_err      = r1_ack & err_q;
   assign m_memread   = (state == ISSUE) & ~lat_we;
   assign m_memwrite  = (state == ISSUE) &  lat_we;
   assign m_addr      = lat_addr;
   assign m_wdata     = lat_wdata;
   assign m_sign_mask = lat_mask;
   assign busy        = (state != IDLE);

endmodule
